// File: rtl/bin2bcd_seq_if.sv
// Bus for the sequential binary-to-BCD converter: START/BIN_IN request, BUSY/DONE status, result digits.
// Compile with +define+BCD_SAT_EN on the design to saturate overflowing results to 9999.
interface bin2bcd_seq_if #(
  parameter int IN_WIDTH = 14
);
  logic                START;
  logic [IN_WIDTH-1:0] BIN_IN;
  logic                BUSY;
  logic                DONE;
  logic                OVF;
  logic [3:0]          DIG0;
  logic [3:0]          DIG1;
  logic [3:0]          DIG2;
  logic [3:0]          DIG3;

  modport master (
    output START, BIN_IN,
    input  BUSY, DONE, OVF, DIG0, DIG1, DIG2, DIG3
  );

  modport slave (
    input  START, BIN_IN,
    output BUSY, DONE, OVF, DIG0, DIG1, DIG2, DIG3
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock, IN_WIDTH steps per conversion.
// Optional macro BCD_SAT_EN: overflowing results (> 9999) register digits 9,9,9,9 instead of the low digits.
module bin2bcd_seq #(
  parameter int IN_WIDTH = 14
) (
  input  logic              CLK,
  input  logic              RESETN,
  bin2bcd_seq_if.slave      bus,
  output logic              dbg_state_o
);
  // Handshake: START is taken on a rising edge only while BUSY=0; BIN_IN is captured on that edge.
  // BUSY stays high through the shift steps; DONE pulses one cycle when DIG*/OVF carry a new result.

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [IN_WIDTH-1:0] sr_q, sr_d;
  logic [19:0]         acc_q, acc_d, acc_adj;
  logic [3:0]          cnt_q, cnt_d;
  logic [15:0]         dig_q, dig_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                busy;
  logic                last_step;

  assign last_step = (cnt_q == 4'(IN_WIDTH - 1));

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.START) state_d = SHIFT;
      SHIFT:   if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == SHIFT);
    dbg_state_o = state_q;
  end

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    sr_d   = sr_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    dig_d  = dig_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.START) begin
        sr_d  = bus.BIN_IN;
        acc_d = '0;
        cnt_d = '0;
      end
    end else begin
      acc_d = (acc_adj << 1) | 20'(sr_q[IN_WIDTH-1]);
      sr_d  = sr_q << 1;
      cnt_d = cnt_q + 4'd1;
      if (last_step) begin
        done_d = 1'b1;
        ovf_d  = |acc_d[19:16];
`ifdef BCD_SAT_EN
        dig_d  = ovf_d ? 16'h9999 : acc_d[15:0];
`else
        dig_d  = acc_d[15:0];
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sr_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      dig_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      dig_q  <= dig_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  assign bus.BUSY = busy;
  assign bus.DONE = done_q;
  assign bus.OVF  = ovf_q;
  assign bus.DIG0 = dig_q[3:0];
  assign bus.DIG1 = dig_q[7:4];
  assign bus.DIG2 = dig_q[11:8];
  assign bus.DIG3 = dig_q[15:12];
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: arithmetic reference model checked every cycle, plus literal expectations.
module tb_bin2bcd_seq;
  localparam int IN_WIDTH = 14;

  logic CLK;
  logic RESETN;
  logic dbg_state;
  int   n_vec;
  int   n_err;

  bin2bcd_seq_if #(.IN_WIDTH(IN_WIDTH)) bus ();

  bin2bcd_seq #(.IN_WIDTH(IN_WIDTH)) dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference model: result = {ovf, thousands, hundreds, tens, units} from decimal arithmetic
  function automatic logic [16:0] model_result(input int v);
    logic       ovf;
    int         d;
    logic [15:0] dg;
    ovf = (v > 9999);
    d   = v % 10000;
    dg  = {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
`ifdef BCD_SAT_EN
    if (ovf) dg = 16'h9999;
`endif
    return {ovf, dg};
  endfunction

  // timing model: a conversion occupies IN_WIDTH busy cycles, then one DONE cycle in which START is accepted again
  logic [16:0] exp_q[$];
  logic        m_active;
  int          m_cyc;

  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      m_active <= 1'b0;
      m_cyc    <= 0;
      exp_q.delete();
    end else if (!(m_active && m_cyc < IN_WIDTH)) begin
      if (bus.START) begin
        m_active <= 1'b1;
        m_cyc    <= 0;
        exp_q.push_back(model_result(int'(bus.BIN_IN)));
      end else begin
        m_active <= 1'b0;
      end
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [16:0] dut_res();
    return {bus.OVF, bus.DIG3, bus.DIG2, bus.DIG1, bus.DIG0};
  endfunction

  // scoreboard: compare every cycle against the model
  logic [16:0] m_hold;
  always @(negedge CLK) begin
    if (!RESETN) begin
      m_hold = '0;
      check("rst_busy", 32'(bus.BUSY), 32'd0);
      check("rst_done", 32'(bus.DONE), 32'd0);
      check("rst_res", 32'(dut_res()), 32'd0);
    end else begin
      check("busy", 32'(bus.BUSY), 32'(m_active && m_cyc < IN_WIDTH));
      check("done", 32'(bus.DONE), 32'(m_active && m_cyc == IN_WIDTH));
      if (m_active && m_cyc == IN_WIDTH) begin
        if (exp_q.size() == 0) check("sb_empty", 32'd1, 32'd0);
        else m_hold = exp_q.pop_front();
      end
      check("result", 32'(dut_res()), 32'(m_hold));
    end
  end

  // driver: pulse START with v, wait for DONE (bounded), pin latency/busy/result to literals
  task automatic run_conv(input int v, input logic [16:0] lit, input string nm);
    int lat;
    int bcnt;
    bit seen;
    bus.START  = 1'b1;
    bus.BIN_IN = IN_WIDTH'(v);
    lat = 0; bcnt = 0; seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge CLK);
      bus.START = 1'b0;
      if (bus.BUSY) bcnt++;
      if (bus.DONE) begin seen = 1'b1; lat = i; end
    end
    check({nm, "_seen"}, 32'(seen), 32'd1);
    check({nm, "_lat"}, 32'(lat), 32'd15);
    check({nm, "_busy"}, 32'(bcnt), 32'd14);
    check({nm, "_lit"}, 32'(dut_res()), 32'(lit));
    @(negedge CLK);
    check({nm, "_hold"}, 32'(dut_res()), 32'(lit));
    check({nm, "_1pulse"}, 32'(bus.DONE), 32'd0);
  endtask

  task automatic wait_done(input string nm, output int cyc);
    bit seen;
    seen = 1'b0; cyc = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge CLK);
      if (bus.DONE) begin seen = 1'b1; cyc = i; end
    end
    check({nm, "_seen"}, 32'(seen), 32'd1);
  endtask

`ifdef BCD_SAT_EN
  localparam logic [16:0] LIT_10000 = 17'h1_9999;
  localparam logic [16:0] LIT_16383 = 17'h1_9999;
`else
  localparam logic [16:0] LIT_10000 = 17'h1_0000;
  localparam logic [16:0] LIT_16383 = 17'h1_6383;
`endif

  int vals[6] = '{9, 10, 99, 100, 999, 1000};
  logic [16:0] lits[6] = '{17'h0_0009, 17'h0_0010, 17'h0_0099, 17'h0_0100, 17'h0_0999, 17'h0_1000};

  initial begin
    int c;
    int dcount;
    n_vec = 0; n_err = 0;
    bus.START = 1'b0; bus.BIN_IN = '0;
    RESETN = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_res", 32'(dut_res()), 32'd0);
    check("reset_busy", 32'(bus.BUSY), 32'd0);
    RESETN = 1'b1;

    // model self-pins
    check("model_1234", 32'(model_result(1234)), 32'h0_1234);
    check("model_16383", 32'(model_result(16383)), 32'(LIT_16383));

    run_conv(1234, 17'h0_1234, "v1234");
    run_conv(0, 17'h0_0000, "v0");
    run_conv(9999, 17'h0_9999, "v9999");
    run_conv(10000, LIT_10000, "v10000");
    run_conv(16383, LIT_16383, "v16383");
    for (int i = 0; i < 6; i++) run_conv(vals[i], lits[i], "tbl");

    // START during BUSY is ignored and BIN_IN changes are not seen
    bus.START = 1'b1; bus.BIN_IN = 14'd42;
    @(negedge CLK); bus.START = 1'b0;
    repeat (4) @(negedge CLK);
    bus.BIN_IN = 14'd77; bus.START = 1'b1;
    @(negedge CLK); bus.START = 1'b0;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.DONE) begin
        dcount++;
        check("ign_res", 32'(dut_res()), 32'h0_0042);
      end
      @(negedge CLK);
    end
    check("ign_ndone", 32'(dcount), 32'd1);

    // START held high: back-to-back conversions re-sample BIN_IN, period 15
    bus.START = 1'b1; bus.BIN_IN = 14'd5;
    @(negedge CLK); bus.BIN_IN = 14'd6;
    wait_done("held1", c);
    check("held1_lat", 32'(c), 32'd14);
    check("held1_res", 32'(dut_res()), 32'h0_0005);
    wait_done("held2", c);
    bus.START = 1'b0;
    check("held2_per", 32'(c), 32'd15);
    check("held2_res", 32'(dut_res()), 32'h0_0006);
    repeat (2) @(negedge CLK);

    // reset mid-conversion aborts with no DONE
    bus.START = 1'b1; bus.BIN_IN = 14'd8888;
    @(negedge CLK); bus.START = 1'b0;
    repeat (6) @(negedge CLK);
    #1 RESETN = 1'b0;
    dcount = 0;
    repeat (3) begin
      @(negedge CLK);
      if (bus.DONE) dcount++;
      check("abort_res", 32'(dut_res()), 32'd0);
      check("abort_busy", 32'(bus.BUSY), 32'd0);
    end
    RESETN = 1'b1;
    repeat (20) begin
      @(negedge CLK);
      if (bus.DONE) dcount++;
    end
    check("abort_nodone", 32'(dcount), 32'd0);
    run_conv(8888, 17'h0_8888, "v8888");

    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
